fp_align_acc: RTL and testbench

Downstream accumulation stage for the bit-serial fp16×int multiplier. It consumes one partial product per strobe: sign, 5-bit fp16 exponent and 14-bit unsigned 4.10 fixed-point magnitude. It aligns each product to a running block exponent and accumulates it into a signed fixed-point register. When a group ends it normalizes the sum to an fp16 result. It connects directly to the multiplier's sign/exponent/mantissa/start-accumulate outputs and feeds the result writeback.

---
 rtl/fp_int_pkg.sv | 19 +
 rtl/fp_align_acc_if.sv | 26 ++
 rtl/fp_align_acc_lod.sv | 21 ++
 rtl/fp_align_acc.sv | 162 ++++++++++++++++
 tb/tb_fp_align_acc.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_int_pkg.sv
// Shared fp16 / product-format constants and the accumulator state encoding
// used across the fp16 x int multiply-accumulate path.
package fp_int_pkg;

  localparam int FP16_EXP_W  = 5;
  localparam int FP16_MANT_W = 10;
  localparam int FP16_BIAS   = 15;

  localparam int PROD_MANT_W = 14;
  localparam int PROD_FRAC_W = 10;

  localparam logic [15:0] FP16_MAX_FINITE = 16'h7BFF;

  typedef enum logic {
    EMPTY = 1'b0,
    ACC   = 1'b1
  } acc_state_e;

endpackage

// File: rtl/fp_align_acc_if.sv
// Operand strobe from the multiplier and the fp16 result toward writeback.
interface fp_align_acc_if;
  import fp_int_pkg::*;

  logic                   in_valid;
  logic                   in_sign;
  logic [FP16_EXP_W-1:0]  in_exp;
  logic [PROD_MANT_W-1:0] in_mant;
  logic                   in_last;

  logic                   out_valid;
  logic [15:0]            out_result;
  logic                   out_overflow;
  logic                   busy;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_last,
    input  out_valid, out_result, out_overflow, busy
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_last,
    output out_valid, out_result, out_overflow, busy
  );

endinterface

// File: rtl/fp_align_acc_lod.sv
// Combinational leading-one detector: index of the highest set bit plus a
// zero flag for an all-zero input.
module leading_one_detector #(
  parameter int W = 32
) (
  input  logic [W-1:0]         vec,
  output logic [$clog2(W)-1:0] idx,
  output logic                 zero
);
  localparam int IDX_W = $clog2(W);

  always_comb begin
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign zero = ~|vec;

endmodule

// File: rtl/fp_align_acc.sv
// Aligns signed fixed-point products to a running block exponent, accumulates
// them with saturation, and normalizes each closed group to an fp16 result.
module fp_align_acc
  import fp_int_pkg::*;
#(
  parameter int ACC_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  fp_align_acc_if.slave bus
);
  localparam int W     = ACC_WIDTH;
  localparam int IDX_W = $clog2(W);

  acc_state_e state_q, state_d;
  logic signed [W-1:0]   acc_mant_q, acc_mant_d;
  logic [FP16_EXP_W-1:0] acc_exp_q, acc_exp_d;
  logic                  ovf_q, ovf_d;
  logic                  snap_valid_q, snap_valid_d;
  logic signed [W-1:0]   snap_mant_q, snap_mant_d;
  logic [FP16_EXP_W-1:0] snap_exp_q, snap_exp_d;
  logic                  snap_ovf_q, snap_ovf_d;
  logic                  out_valid_q, out_valid_d;
  logic [15:0]           out_result_q, out_result_d;
  logic                  out_ovf_q, out_ovf_d;
  logic                  busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.in_valid) state_d = bus.in_last ? EMPTY : ACC;
  end

  always_comb begin
    busy = (state_q == ACC) || snap_valid_q;
  end

  // Alignment: whichever side has the smaller exponent is shifted down.
  logic signed [W-1:0]   op, base_mant, a_term, b_term, sum_sat;
  logic [FP16_EXP_W-1:0] base_exp, diff, sh, new_exp;
  logic                  exp_up, base_ovf, sum_ovf;
  logic signed [W:0]     sum;

  always_comb begin
    op = {{(W-PROD_MANT_W){1'b0}}, bus.in_mant};
    if (bus.in_sign) op = -op;
    if (bus.in_exp == '0) op = '0;
    base_mant = (state_q == ACC) ? acc_mant_q : '0;
    base_exp  = (state_q == ACC) ? acc_exp_q : bus.in_exp;
    base_ovf  = (state_q == ACC) && ovf_q;
    exp_up    = bus.in_exp > base_exp;
    diff      = exp_up ? (bus.in_exp - base_exp) : (base_exp - bus.in_exp);
    sh        = (int'(diff) > W - 1) ? FP16_EXP_W'(W - 1) : diff;
    a_term    = exp_up ? (base_mant >>> sh) : base_mant;
    b_term    = exp_up ? op : (op >>> sh);
    new_exp   = exp_up ? bus.in_exp : base_exp;
    sum       = {a_term[W-1], a_term} + {b_term[W-1], b_term};
    sum_ovf   = sum[W] ^ sum[W-1];
    if (sum_ovf) sum_sat = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else         sum_sat = sum[W-1:0];
  end

  always_comb begin
    acc_mant_d   = acc_mant_q;
    acc_exp_d    = acc_exp_q;
    ovf_d        = ovf_q;
    snap_valid_d = bus.in_valid && bus.in_last;
    snap_mant_d  = snap_mant_q;
    snap_exp_d   = snap_exp_q;
    snap_ovf_d   = snap_ovf_q;
    if (bus.in_valid) begin
      if (bus.in_last) begin
        snap_mant_d = sum_sat;
        snap_exp_d  = new_exp;
        snap_ovf_d  = base_ovf || sum_ovf;
        acc_mant_d  = '0;
        acc_exp_d   = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_mant_d  = sum_sat;
        acc_exp_d   = new_exp;
        ovf_d       = base_ovf || sum_ovf;
      end
    end
  end

  logic [W-1:0]           mag;
  logic [IDX_W-1:0]       lead_idx;
  logic                   mag_zero;
  logic signed [7:0]      norm_exp;
  logic [FP16_MANT_W-1:0] frac;
  logic [15:0]            norm_result;
  logic                   res_sign;

  assign mag = snap_mant_q[W-1] ? -snap_mant_q : snap_mant_q;

  leading_one_detector #(.W(W)) u_lod (
    .vec  (mag),
    .idx  (lead_idx),
    .zero (mag_zero)
  );

  // Product LSB weight 2^(exp-25) plus bias 15 leaves p + exp - 10 as the fp16 exponent.
  always_comb begin
    res_sign = snap_mant_q[W-1];
    norm_exp = 8'(lead_idx) + 8'(snap_exp_q) - 8'(PROD_FRAC_W);
    if (int'(lead_idx) >= FP16_MANT_W)
      frac = FP16_MANT_W'(mag >> (int'(lead_idx) - FP16_MANT_W));
    else
      frac = FP16_MANT_W'(mag << (FP16_MANT_W - int'(lead_idx)));
    if (mag_zero)                  norm_result = 16'h0000;
    else if (norm_exp <= 8'sd0)    norm_result = {res_sign, 15'h0000};
    else if (norm_exp >= 8'sd31)   norm_result = {res_sign, FP16_MAX_FINITE[14:0]};
    else                           norm_result = {res_sign, norm_exp[FP16_EXP_W-1:0], frac};
  end

  always_comb begin
    out_valid_d  = snap_valid_q;
    out_result_d = out_result_q;
    out_ovf_d    = out_ovf_q;
    if (snap_valid_q) begin
      out_result_d = norm_result;
      out_ovf_d    = snap_ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_mant_q   <= '0;
      acc_exp_q    <= '0;
      ovf_q        <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_mant_q  <= '0;
      snap_exp_q   <= '0;
      snap_ovf_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= 16'h0000;
      out_ovf_q    <= 1'b0;
    end else begin
      acc_mant_q   <= acc_mant_d;
      acc_exp_q    <= acc_exp_d;
      ovf_q        <= ovf_d;
      snap_valid_q <= snap_valid_d;
      snap_mant_q  <= snap_mant_d;
      snap_exp_q   <= snap_exp_d;
      snap_ovf_q   <= snap_ovf_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_overflow = out_ovf_q;
  assign bus.busy         = busy;

endmodule

// File: tb/tb_fp_align_acc.sv
// Drives identical operand streams into a 32-bit and a 16-bit accumulator and
// checks both every cycle against an arithmetic model plus literal group results.
module tb_fp_align_acc;

  logic clk;
  logic rst;
  logic       t_valid, t_sign, t_last;
  logic [4:0] t_exp;
  logic [13:0] t_mant;

  int total = 0;
  int bad   = 0;

  fp_align_acc_if ifc32 ();
  fp_align_acc_if ifc16 ();

  assign ifc32.in_valid = t_valid;
  assign ifc32.in_sign  = t_sign;
  assign ifc32.in_exp   = t_exp;
  assign ifc32.in_mant  = t_mant;
  assign ifc32.in_last  = t_last;
  assign ifc16.in_valid = t_valid;
  assign ifc16.in_sign  = t_sign;
  assign ifc16.in_exp   = t_exp;
  assign ifc16.in_mant  = t_mant;
  assign ifc16.in_last  = t_last;

  fp_align_acc #(.ACC_WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(ifc32));
  fp_align_acc #(.ACC_WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(ifc16));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model (index 0: 32-bit, 1: 16-bit) ----------------
  bit          m_open [2];
  longint      m_acc  [2];
  int          m_exp  [2];
  bit          m_ovf  [2];
  bit          ms_v   [2];
  longint      ms_mant[2];
  int          ms_exp [2];
  bit          ms_ovf [2];
  bit          mo_v   [2];
  logic [15:0] mo_res [2];
  bit          mo_ovf [2];

  logic [16:0] mq0[$], mq1[$], dq0[$], dq1[$];

  function automatic longint floor_div_pow2(longint x, int d);
    longint p, q;
    p = longint'(1) << d;
    q = x / p;
    if ((x % p) != 0 && x < 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [15:0] to_fp16(longint x, int ex);
    logic   s;
    longint mag, frac;
    int     p, e;
    s   = (x < 0);
    mag = s ? -x : x;
    if (mag == 0) return 16'h0000;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    e = p + ex - 10;
    if (e <= 0) return {s, 15'h0000};
    if (e >= 31) return s ? 16'hFBFF : 16'h7BFF;
    frac = (mag * 1024) / (longint'(1) << p) - 1024;
    return {s, e[4:0], frac[9:0]};
  endfunction

  function automatic void model_reset(int k);
    m_open[k] = 0; m_acc[k] = 0; m_exp[k] = 0; m_ovf[k] = 0;
    ms_v[k] = 0; ms_mant[k] = 0; ms_exp[k] = 0; ms_ovf[k] = 0;
    mo_v[k] = 0; mo_res[k] = 16'h0000; mo_ovf[k] = 0;
  endfunction

  function automatic void model_step(int k, int w);
    longint op, acc, sum, maxv, minv;
    int     ae, d;
    bit     ov;
    mo_v[k] = ms_v[k];
    if (ms_v[k]) begin
      mo_res[k] = to_fp16(ms_mant[k], ms_exp[k]);
      mo_ovf[k] = ms_ovf[k];
      if (k == 0) mq0.push_back({mo_ovf[k], mo_res[k]});
      else        mq1.push_back({mo_ovf[k], mo_res[k]});
    end
    ms_v[k] = 0;
    if (t_valid) begin
      op = (t_exp == 0) ? 0 : (t_sign ? -longint'(t_mant) : longint'(t_mant));
      if (m_open[k]) begin acc = m_acc[k]; ae = m_exp[k]; ov = m_ovf[k]; end
      else           begin acc = 0; ae = int'(t_exp); ov = 0; end
      d = (int'(t_exp) > ae) ? int'(t_exp) - ae : ae - int'(t_exp);
      if (d > w - 1) d = w - 1;
      if (int'(t_exp) > ae) begin acc = floor_div_pow2(acc, d); ae = int'(t_exp); end
      else op = floor_div_pow2(op, d);
      sum  = acc + op;
      maxv = (longint'(1) << (w - 1)) - 1;
      minv = -(longint'(1) << (w - 1));
      if (sum > maxv) begin sum = maxv; ov = 1; end
      if (sum < minv) begin sum = minv; ov = 1; end
      if (t_last) begin
        ms_v[k] = 1; ms_mant[k] = sum; ms_exp[k] = ae; ms_ovf[k] = ov; m_open[k] = 0;
      end else begin
        m_open[k] = 1; m_acc[k] = sum; m_exp[k] = ae; m_ovf[k] = ov;
      end
    end
  endfunction

  // ---------------- checking ----------------
  function automatic void cmp(string nm, int k, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h want %0h", nm, k, act, req);
    end
  endfunction

  function automatic void check_inst(int k, logic v, logic [15:0] r, logic o, logic b);
    cmp("out_valid", k, 32'(v), 32'(mo_v[k]));
    cmp("out_result", k, 32'(r), 32'(mo_res[k]));
    cmp("out_overflow", k, 32'(o), 32'(mo_ovf[k]));
    cmp("busy", k, 32'(b), 32'(m_open[k] | ms_v[k]));
    if (v === 1'b1) begin
      $display("out dut%0d result=%h ovf=%0d", k, r, o);
      if (k == 0) dq0.push_back({o, r});
      else        dq1.push_back({o, r});
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        model_reset(0);
        model_reset(1);
      end else begin
        model_step(0, 32);
        model_step(1, 16);
      end
      #1;
      check_inst(0, ifc32.out_valid, ifc32.out_result, ifc32.out_overflow, ifc32.busy);
      check_inst(1, ifc16.out_valid, ifc16.out_result, ifc16.out_overflow, ifc16.busy);
    end
  end

  function automatic int dsize(int k);
    return (k == 0) ? dq0.size() : dq1.size();
  endfunction

  task automatic expect_grp(int k, logic [15:0] res, logic ovf);
    int n;
    logic [16:0] d, m;
    n = 0;
    while (dsize(k) == 0 && n < 10) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (dsize(k) == 0) begin
      total++;
      bad++;
      $display("FAIL group_timeout dut%0d: got no out_valid want result %h", k, res);
      return;
    end
    d = (k == 0) ? dq0.pop_front() : dq1.pop_front();
    cmp("group_result", k, 32'(d[15:0]), 32'(res));
    cmp("group_ovf", k, 32'(d[16]), 32'(ovf));
    if (((k == 0) ? mq0.size() : mq1.size()) == 0) begin
      total++;
      bad++;
      $display("FAIL model_missing dut%0d: got none want %h", k, res);
    end else begin
      m = (k == 0) ? mq0.pop_front() : mq1.pop_front();
      cmp("model_result", k, 32'(m[15:0]), 32'(res));
      cmp("model_ovf", k, 32'(m[16]), 32'(ovf));
    end
  endtask

  task automatic grp(logic [15:0] r32, logic o32, logic [15:0] r16, logic o16);
    expect_grp(0, r32, o32);
    expect_grp(1, r16, o16);
  endtask

  task automatic send(bit v, bit s, logic [4:0] e, logic [13:0] m, bit l);
    @(negedge clk);
    t_valid = v; t_sign = s; t_exp = e; t_mant = m; t_last = l;
  endtask

  task automatic idle(int n);
    repeat (n) send(0, 0, 5'd0, 14'd0, 0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b0;
    t_valid = 0; t_sign = 0; t_exp = '0; t_mant = '0; t_last = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(1);

    send(1, 0, 5'd15, 14'h400, 1);
    idle(1);
    grp(16'h3C00, 0, 16'h3C00, 0);

    send(1, 0, 5'd16, 14'h400, 0);
    send(0, 0, 5'd15, 14'h400, 1);
    send(1, 1, 5'd15, 14'h400, 1);
    send(1, 0, 5'd15, 14'h400, 0);
    send(1, 1, 5'd15, 14'h400, 1);
    idle(1);
    grp(16'h3C00, 0, 16'h3C00, 0);
    grp(16'h0000, 0, 16'h0000, 0);

    send(1, 0, 5'd15, 14'h400, 0);
    send(1, 0, 5'd17, 14'h400, 1);
    idle(1);
    grp(16'h4500, 0, 16'h4500, 0);

    send(1, 0, 5'd30, 14'h3FFF, 1);
    send(1, 1, 5'd30, 14'h3FFF, 1);
    send(1, 0, 5'd0, 14'h3FFF, 1);
    idle(1);
    grp(16'h7BFF, 0, 16'h7BFF, 0);
    grp(16'hFBFF, 0, 16'hFBFF, 0);
    grp(16'h0000, 0, 16'h0000, 0);

    for (int i = 0; i < 8; i++) send(1, 0, 5'd15, 14'h3FFF, i == 7);
    idle(1);
    grp(16'h57FF, 0, 16'h4FFF, 1);

    for (int i = 0; i < 4; i++) send(1, 0, (i % 2 == 0) ? 5'd15 : 5'd16, 14'h400, 1);
    idle(1);
    grp(16'h3C00, 0, 16'h3C00, 0);
    grp(16'h4000, 0, 16'h4000, 0);
    grp(16'h3C00, 0, 16'h3C00, 0);
    grp(16'h4000, 0, 16'h4000, 0);

    repeat (3) send(1, 0, 5'd15, 14'h400, 0);
    @(negedge clk);
    rst = 1'b0; t_valid = 0; t_last = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send(1, 0, 5'd16, 14'h400, 1);
    @(negedge clk);
    rst = 1'b0; t_valid = 0; t_last = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(3);
    cmp("no_spurious_out", 0, 32'(dq0.size()), 32'd0);
    cmp("no_spurious_out", 1, 32'(dq1.size()), 32'd0);
    send(1, 0, 5'd15, 14'h400, 1);
    idle(1);
    grp(16'h3C00, 0, 16'h3C00, 0);

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
